// File: rtl/ntt_pkg.sv
// Shared Kyber NTT/INTT definitions: field constants, zeta ROM and modular multiply.
package ntt_pkg;

    localparam int unsigned Q         = 3329;
    localparam int unsigned N         = 256;
    localparam int unsigned W         = 12;
    localparam int unsigned F_INV     = 3303;
    localparam int unsigned BARRETT_M = 5039;   // floor(2^24 / Q)

    typedef logic [W-1:0] coeff_t;
    typedef logic [W:0]   coeff_ext_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BFLY,
        S_SCALE,
        S_DONE
    } state_e;

    // ZETAS[z] = 17^bitrev7(z) mod Q
    localparam coeff_t ZETAS [128] = '{
        12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
        12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
        12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
        12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
        12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
        12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
        12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
        12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
        12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
        12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
        12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
        12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
        12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
        12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
        12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
        12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
    };

    // Barrett reduction of a 24-bit product; the estimate is at most one Q low.
    function automatic coeff_t mod_mul(input coeff_t a, input coeff_t b);
        logic [23:0] p;
        logic [36:0] t;
        logic [11:0] qh;
        logic [23:0] r;
        p  = 24'(a) * 24'(b);
        t  = 37'(p) * 37'(BARRETT_M);
        qh = 12'(t >> 24);
        r  = p - 24'(qh) * 24'(Q);
        if (r >= 24'(Q)) begin
            r = r - 24'(Q);
        end
        return 12'(r);
    endfunction

endpackage

// File: rtl/intt_gs_bf.sv
// Combinational Gentleman-Sande butterfly; scale mode returns a*F_INV on a_c and passes b through.
module intt_gs_bf
    import ntt_pkg::*;
(
    input  coeff_t a_i,
    input  coeff_t b_i,
    input  coeff_t zeta_i,
    input  logic   scale_i,
    output coeff_t a_c,
    output coeff_t b_c
);

    coeff_ext_t sum;
    coeff_ext_t diff;
    coeff_t     sum_r;
    coeff_t     diff_r;
    coeff_t     mul_x;
    coeff_t     mul_y;
    coeff_t     prod;

    // One multiplier shared between the twiddle product and the final scaling.
    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, b_i};
        sum_r  = (sum >= coeff_ext_t'(Q)) ? W'(sum - coeff_ext_t'(Q)) : W'(sum);
        diff   = {1'b0, b_i} - {1'b0, a_i};
        diff_r = diff[W] ? W'(diff + coeff_ext_t'(Q)) : W'(diff);
        mul_x  = scale_i ? a_i : diff_r;
        mul_y  = scale_i ? W'(F_INV) : zeta_i;
        prod   = mod_mul(mul_x, mul_y);
        a_c    = scale_i ? prod : sum_r;
        b_c    = scale_i ? b_i : prod;
    end

endmodule

// File: rtl/intt.sv
// Kyber inverse NTT: 7 GS layers at one butterfly per cycle, then 256 cycles of 128^-1 scaling.
module intt
    import ntt_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   start_i,
    input  coeff_t coeff_i [N],
    output coeff_t coeff_o [N],
    output logic   done_o
);

    state_e     state_q, state_d;
    logic [2:0] layer_q, layer_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    coeff_t     a_q [N];
    coeff_t     a_d [N];

    logic [3:0] sh;
    logic [7:0] len;
    logic [7:0] grp;
    logic [7:0] j;
    logic [7:0] jl;
    logic [6:0] zidx;
    logic       scale;
    coeff_t     bf_a, bf_b, zeta, bf_a_c, bf_b_c;

    // Butterfly b of layer l: group g = b >> (l+1), pair (j, j+len), twiddle index counts down.
    always_comb begin
        sh    = 4'(layer_q) + 4'd1;
        len   = 8'd2 << layer_q;
        grp   = {1'b0, cnt_q[6:0]} >> sh;
        j     = (grp << (sh + 4'd1)) | ({1'b0, cnt_q[6:0]} & (len - 8'd1));
        jl    = j + len;
        zidx  = 7'((8'd128 >> layer_q) - 8'd1 - grp);
        scale = (state_q == S_SCALE);
        bf_a  = scale ? a_q[cnt_q] : a_q[j];
        bf_b  = a_q[jl];
        zeta  = ZETAS[zidx];
    end

    intt_gs_bf u_bf (
        .a_i     (bf_a),
        .b_i     (bf_b),
        .zeta_i  (zeta),
        .scale_i (scale),
        .a_c     (bf_a_c),
        .b_c     (bf_b_c)
    );

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        a_d     = a_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    a_d     = coeff_i;
                    layer_d = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = S_BFLY;
                end
            end
            S_BFLY: begin
                a_d[j]  = bf_a_c;
                a_d[jl] = bf_b_c;
                if (cnt_q[6:0] == 7'd127) begin
                    cnt_d = '0;
                    if (layer_q == 3'd6) begin
                        state_d = S_SCALE;
                    end else begin
                        layer_d = layer_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SCALE: begin
                a_d[cnt_q] = bf_a_c;
                if (cnt_q == 8'd255) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                a_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            a_q     <= a_d;
        end
    end

    assign coeff_o = a_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_intt.sv
// Scoreboard bench for intt against a FIPS 203 Alg. 9/10 reference model.
`timescale 1ns/1ps
module tb_intt;

    localparam int QM   = 3329;
    localparam int LAT  = 1152;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] cin  [256];
    logic [11:0] cout [256];
    logic        done;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int zt [128];
    logic [3071:0] exp_q [$];
    int            due_q [$];
    logic          done_prev = 1'b0;

    intt dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .coeff_i (cin),
        .coeff_o (cout),
        .done_o  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [3071:0] pack(input int v [256]);
        logic [3071:0] p;
        for (int i = 0; i < 256; i++) p[i*12 +: 12] = 12'(v[i]);
        return p;
    endfunction

    // FIPS 203 Alg. 10 followed by scaling with 128^-1.
    function automatic void intt_model(input int f_in [256], output int f [256]);
        int k, t;
        f = f_in;
        k = 127;
        for (int len = 2; len <= 128; len = len * 2) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                for (int jj = st; jj < st + len; jj++) begin
                    t          = f[jj];
                    f[jj]      = (t + f[jj+len]) % QM;
                    f[jj+len]  = (zt[k] * ((f[jj+len] - t + QM) % QM)) % QM;
                end
                k--;
            end
        end
        for (int i = 0; i < 256; i++) f[i] = (f[i] * 3303) % QM;
    endfunction

    // FIPS 203 Alg. 9, used to build round-trip stimulus.
    function automatic void ntt_model(input int f_in [256], output int f [256]);
        int k, t;
        f = f_in;
        k = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                for (int jj = st; jj < st + len; jj++) begin
                    t         = (zt[k] * f[jj+len]) % QM;
                    f[jj+len] = (f[jj] - t + QM) % QM;
                    f[jj]     = (f[jj] + t) % QM;
                end
                k++;
            end
        end
    endfunction

    task automatic run(input int v [256], input int expv [256]);
        @(negedge clk);
        for (int i = 0; i < 256; i++) cin[i] = 12'(v[i]);
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(pack(expv));
        due_q.push_back(cyc + LAT);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", exp_q.size(), 0);
        exp_q.delete();
        due_q.delete();
    endtask

    // Monitor: on each rising done_o, pop and compare timing, contents and range.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [3071:0] e;
                int due, k, mx;
                e   = exp_q.pop_front();
                due = due_q.pop_front();
                check("done_latency", cyc, due);
                k = 0;
                for (int i = 255; i >= 0; i--) if (cout[i] !== e[i*12 +: 12]) k = i;
                check($sformatf("coeff_o[%0d]", k), int'(cout[k]), int'(e[k*12 +: 12]));
                mx = 0;
                for (int i = 0; i < 256; i++) if (int'(cout[i]) > mx) mx = int'(cout[i]);
                check("coeff_range", int'(mx < QM), 1);
            end
        end
        if (done) begin
            for (int i = 0; i < 256; i++) begin
                if (cout[i] >= 12'd3329) begin
                    n_err++;
                    $display("FAIL range_hold: coeff_o[%0d]=%0d at cycle %0d", i, cout[i], cyc);
                end
            end
        end
        done_prev = done;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int v [256];
        int e [256];
        int b [256];
        int k;

        for (int z = 0; z < 128; z++) begin
            int br, p;
            br = 0;
            for (int bit_i = 0; bit_i < 7; bit_i++) if (z[bit_i]) br |= 1 << (6 - bit_i);
            p = 1;
            for (int n = 0; n < br; n++) p = (p * 17) % QM;
            zt[z] = p;
        end
        for (int i = 0; i < 256; i++) cin[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", int'(done), 0);
        k = 0;
        for (int i = 255; i >= 0; i--) if (cout[i] != 0) k = i;
        check("rst_coeff", int'(cout[k]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // NTT-domain constant 1 -> delta at index 0
        for (int i = 0; i < 256; i++) begin
            v[i] = (i % 2 == 0) ? 1 : 0;
            e[i] = (i == 0) ? 1 : 0;
        end
        run(v, e);
        wait_done();

        // All zero, then back-to-back restart from DONE
        for (int i = 0; i < 256; i++) v[i] = 0;
        run(v, v);
        wait_done();
        check("done_held", int'(done), 1);
        run(v, v);
        check("done_drop", int'(done), 0);
        wait_done();

        // Round trip of the ternary vector
        for (int i = 0; i < 256; i++) e[i] = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 3328 : 1);
        ntt_model(e, v);
        run(v, e);
        wait_done();

        // Boundary: every input at Q-1
        for (int i = 0; i < 256; i++) v[i] = 3328;
        intt_model(v, e);
        run(v, e);
        wait_done();

        // start_i while busy is ignored
        for (int i = 0; i < 256; i++) begin
            v[i] = $urandom_range(0, 3328);
            b[i] = $urandom_range(0, 3328);
        end
        intt_model(v, e);
        run(v, e);
        repeat (9) @(negedge clk);
        for (int i = 0; i < 256; i++) cin[i] = 12'(b[i]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (489) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Asynchronous reset mid-run
        for (int i = 0; i < 256; i++) v[i] = $urandom_range(1, 3328);
        intt_model(v, e);
        run(v, e);
        repeat (600) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        #1;
        check("arst_done", int'(done), 0);
        k = 0;
        for (int i = 255; i >= 0; i--) if (cout[i] != 0) k = i;
        check("arst_coeff", int'(cout[k]), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_after_rst", int'(done), 0);
        run(v, e);
        wait_done();

        // Random canonical vectors
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 256; i++) v[i] = $urandom_range(0, 3328);
            intt_model(v, e);
            run(v, e);
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
